// File: rtl/tl_ul_pkg.sv
// ---------------------------------------------------------------------------
// tl_ul_pkg: shared TileLink-UL opcodes, D-channel layout and responder states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tl_ul_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  localparam int D_W          = 43;
  localparam int D_DATA_LSB   = 0;
  localparam int D_DATA_W     = 32;
  localparam int D_OPCODE_LSB = 32;
  localparam int D_PARAM_LSB  = 35;
  localparam int D_SIZE_LSB   = 37;
  localparam int D_SOURCE_LSB = 39;
  localparam int D_SOURCE_W   = 3;
  localparam int D_ERROR_BIT  = 42;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic [D_W-1:0] pack_d(
    input logic [D_DATA_W-1:0]   data,
    input logic [2:0]            opcode,
    input logic [D_SOURCE_W-1:0] source,
    input logic                  error
  );
    logic [D_W-1:0] d;
    d = '0;
    d[D_DATA_LSB +: D_DATA_W]     = data;
    d[D_OPCODE_LSB +: 3]          = opcode;
    d[D_PARAM_LSB +: 2]           = 2'b00;
    d[D_SIZE_LSB +: 2]            = SIZE_WORD;
    d[D_SOURCE_LSB +: D_SOURCE_W] = source;
    d[D_ERROR_BIT]                = error;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tl_ul_mem_array.sv
// ---------------------------------------------------------------------------
// tl_ul_mem_array: DEPTH x 32 register array, byte-lane writes, combinational read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tl_ul_mem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < 4; k++) begin
      if (we[k]) begin
        mem_d[waddr][8*k +: 8] = wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/tl_ul_datamem_slave.sv
// ---------------------------------------------------------------------------
// tl_ul_datamem_slave: single-outstanding TileLink-UL responder over a data memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tl_ul_datamem_slave
  import tl_ul_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int LATENCY  = 0,
  parameter int SOURCE_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [31:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  input  logic [SOURCE_W-1:0] a_source,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [D_W-1:0]      d_channel
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [3:0]  LAT_LAST   = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [2:0]            opcode_q, opcode_d;
  logic [31:0]           addr_q, addr_d;
  logic [3:0]            mask_q, mask_d;
  logic [31:0]           data_q, data_d;
  logic [SOURCE_W-1:0]   source_q, source_d;
  logic [D_W-1:0]        d_channel_q, d_channel_d;

  logic                  req_err;
  logic [AW-1:0]         word_idx;
  logic [2:0]            src3;
  logic [3:0]            mem_we;
  logic [31:0]           mem_rdata;
  logic [D_W-1:0]        resp;

  generate
    if (SOURCE_W >= D_SOURCE_W) begin : g_src_trunc
      assign src3 = source_q[D_SOURCE_W-1:0];
    end else begin : g_src_ext
      assign src3 = {{(D_SOURCE_W-SOURCE_W){1'b0}}, source_q};
    end
  endgenerate

  assign word_idx = addr_q[AW+1:2];

  always_comb begin
    req_err = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT) ||
              !((opcode_q == PUT_FULL) || (opcode_q == PUT_PARTIAL) || (opcode_q == GET));

    if (req_err) begin
      resp = pack_d('0, (opcode_q == GET) ? ACK_DATA : ACK, src3, 1'b1);
    end else if (opcode_q == GET) begin
      resp = pack_d(mem_rdata, ACK_DATA, src3, 1'b0);
    end else begin
      resp = pack_d('0, ACK, src3, 1'b0);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    data_d      = data_q;
    source_d    = source_q;
    d_channel_d = d_channel_q;
    mem_we      = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (a_valid) begin
          opcode_d = a_opcode;
          addr_d   = a_address;
          mask_d   = a_mask;
          data_d   = a_data;
          source_d = a_source;
          cnt_d    = 4'd0;
          state_d  = (LATENCY > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ACCESS: begin
        // Write and response capture share the same edge; read sees pre-write data.
        if (!req_err) begin
          if (opcode_q == PUT_FULL) begin
            mem_we = 4'b1111;
          end else if (opcode_q == PUT_PARTIAL) begin
            mem_we = mask_q;
          end
        end
        d_channel_d = resp;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (d_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      opcode_q    <= 3'd0;
      addr_q      <= 32'd0;
      mask_q      <= 4'd0;
      data_q      <= 32'd0;
      source_q    <= '0;
      d_channel_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      source_q    <= source_d;
      d_channel_q <= d_channel_d;
    end
  end

  tl_ul_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (word_idx),
    .wdata (data_q),
    .raddr (word_idx),
    .rdata (mem_rdata)
  );

  assign a_ready   = (state_q == ST_IDLE);
  assign d_valid   = (state_q == ST_RESP);
  assign d_channel = d_channel_q;

endmodule

`default_nettype wire

// File: tb/tb_tl_ul_datamem_slave.sv
// ---------------------------------------------------------------------------
// tb_tl_ul_datamem_slave: directed + random bench for two responders (LATENCY 0 and 3)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tl_ul_datamem_slave;
  import tl_ul_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT_A = 0;
  localparam int LAT_B = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid   [2];
  logic [2:0]  a_opcode  [2];
  logic [31:0] a_address [2];
  logic [3:0]  a_mask    [2];
  logic [31:0] a_data    [2];
  logic [2:0]  a_source  [2];
  logic        a_ready   [2];
  logic        d_valid   [2];
  logic        d_ready   [2];
  logic [42:0] d_channel [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ref_mem [2][DEPTH];

  always #5 clk = ~clk;

  tl_ul_datamem_slave #(.DEPTH(DEPTH), .LATENCY(LAT_A), .SOURCE_W(3)) u_dut0 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_opcode(a_opcode[0]),
    .a_address(a_address[0]), .a_mask(a_mask[0]), .a_data(a_data[0]),
    .a_source(a_source[0]), .d_valid(d_valid[0]), .d_ready(d_ready[0]),
    .d_channel(d_channel[0])
  );

  tl_ul_datamem_slave #(.DEPTH(DEPTH), .LATENCY(LAT_B), .SOURCE_W(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_opcode(a_opcode[1]),
    .a_address(a_address[1]), .a_mask(a_mask[1]), .a_data(a_data[1]),
    .a_source(a_source[1]), .d_valid(d_valid[1]), .d_ready(d_ready[1]),
    .d_channel(d_channel[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++)
        ref_mem[i][j] = 32'd0;
  endfunction

  // Reference: applies the request to the word-array model, returns the D beat.
  function automatic logic [42:0] model_txn(input int i, input logic [2:0] op,
      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
      input logic [2:0] src);
    bit          err;
    int          idx;
    logic [31:0] rd;
    logic [2:0]  rop;
    err = (addr % 4 != 0) || (addr >= 4 * DEPTH) || !(op == 0 || op == 1 || op == 4);
    idx = int'(addr / 4) % DEPTH;
    rop = (op == 3'd4) ? 3'd1 : 3'd0;
    rd  = 32'd0;
    if (!err) begin
      if (op == 3'd4) rd = ref_mem[i][idx];
      else if (op == 3'd0) ref_mem[i][idx] = data;
      else
        for (int k = 0; k < 4; k++)
          if (mask[k]) ref_mem[i][idx][8*k +: 8] = data[8*k +: 8];
    end
    return {err, src, 2'b10, 2'b00, rop, rd};
  endfunction

  task automatic drive_req(input int i, input logic [2:0] op, input logic [31:0] addr,
      input logic [3:0] mask, input logic [31:0] data, input logic [2:0] src);
    a_opcode[i]  = op;
    a_address[i] = addr;
    a_mask[i]    = mask;
    a_data[i]    = data;
    a_source[i]  = src;
    a_valid[i]   = 1'b1;
  endtask

  // Called at a negedge; returns #1 after the handshake edge.
  task automatic send_req(input int i, input logic [2:0] op, input logic [31:0] addr,
      input logic [3:0] mask, input logic [31:0] data, input logic [2:0] src);
    bit hs;
    hs = 1'b0;
    drive_req(i, op, addr, mask, data, src);
    for (int c = 0; c < 50; c++) begin
      if (a_ready[i]) begin
        @(posedge clk);
        hs = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("req_accepted", 64'(hs), 64'd1);
    #1 a_valid[i] = 1'b0;
  endtask

  task automatic get_resp(input int i, input logic [42:0] exp, input int holds,
      output logic [42:0] got);
    bit          seen;
    int          c;
    logic [42:0] snap;
    seen = 1'b0;
    got  = '0;
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (d_valid[i]) begin
        seen = 1'b1;
        break;
      end
      chk("busy_a_ready", 64'(a_ready[i]), 64'd0);
    end
    chk("resp_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("latency", 64'(c), 64'(1 + lat_of(i)));
      snap = d_channel[i];
      got  = snap;
      chk("d_channel", 64'(snap), 64'(exp));
      chk("resp_a_ready", 64'(a_ready[i]), 64'd0);
      repeat (holds) begin
        @(negedge clk);
        chk("hold_d_valid", 64'(d_valid[i]), 64'd1);
        chk("hold_d_channel", 64'(d_channel[i]), 64'(snap));
        chk("hold_a_ready", 64'(a_ready[i]), 64'd0);
      end
      d_ready[i] = 1'b1;
      @(posedge clk);
      #1 d_ready[i] = 1'b0;
      @(negedge clk);
      chk("post_a_ready", 64'(a_ready[i]), 64'd1);
      chk("post_d_valid", 64'(d_valid[i]), 64'd0);
    end
  endtask

  task automatic txn(input int i, input logic [2:0] op, input logic [31:0] addr,
      input logic [3:0] mask, input logic [31:0] data, input logic [2:0] src,
      input int holds, output logic [42:0] got);
    logic [42:0] exp;
    exp = model_txn(i, op, addr, mask, data, src);
    send_req(i, op, addr, mask, data, src);
    get_resp(i, exp, holds, got);
  endtask

  task automatic check_idle_after_reset();
    for (int i = 0; i < 2; i++) begin
      chk("rst_a_ready", 64'(a_ready[i]), 64'd1);
      chk("rst_d_valid", 64'(d_valid[i]), 64'd0);
      chk("rst_d_channel", 64'(d_channel[i]), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [42:0] got;
    logic [42:0] exp1;
    logic [42:0] exp2;
    logic [2:0]  ops [10];
    logic [31:0] addr;
    int          r;

    ops = '{3'd0, 3'd1, 3'd1, 3'd4, 3'd4, 3'd4, 3'd0, 3'd2, 3'd3, 3'd7};
    for (int i = 0; i < 2; i++) begin
      a_valid[i] = 1'b0; a_opcode[i] = 3'd0; a_address[i] = 32'd0;
      a_mask[i] = 4'd0; a_data[i] = 32'd0; a_source[i] = 3'd0; d_ready[i] = 1'b0;
    end
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check_idle_after_reset();

    // Directed sequence on the zero-latency responder
    txn(0, PUT_FULL, 32'h10, 4'h0, 32'hDEADBEEF, 3'd2, 0, got);
    chk("put_opcode", 64'(got[34:32]), 64'd0);
    chk("put_source", 64'(got[41:39]), 64'd2);
    chk("put_error", 64'(got[42]), 64'd0);
    txn(0, GET, 32'h10, 4'h0, 32'h0, 3'd1, 0, got);
    chk("get_opcode", 64'(got[34:32]), 64'd1);
    chk("get_data", 64'(got[31:0]), 64'hDEADBEEF);
    txn(0, PUT_PARTIAL, 32'h10, 4'b0101, 32'h11223344, 3'd3, 0, got);
    txn(0, GET, 32'h10, 4'h0, 32'h0, 3'd4, 0, got);
    chk("partial_data", 64'(got[31:0]), 64'hDE22BE44);
    txn(0, GET, 32'h12, 4'h0, 32'h0, 3'd5, 0, got);
    chk("misalign_err", 64'(got[42]), 64'd1);
    chk("misalign_data", 64'(got[31:0]), 64'd0);
    txn(0, GET, 32'h100, 4'h0, 32'h0, 3'd6, 0, got);
    chk("range_err", 64'(got[42]), 64'd1);
    txn(0, 3'd2, 32'h10, 4'hF, 32'h55555555, 3'd7, 0, got);
    chk("badop_err", 64'(got[42]), 64'd1);
    chk("badop_opcode", 64'(got[34:32]), 64'd0);
    txn(0, GET, 32'h10, 4'h0, 32'h0, 3'd0, 5, got);
    chk("unchanged_data", 64'(got[31:0]), 64'hDE22BE44);

    // LATENCY=3: a second request held during the first transaction waits its turn
    txn(1, PUT_FULL, 32'h30, 4'h0, 32'h0BADF00D, 3'd1, 0, got);
    exp1 = model_txn(1, PUT_PARTIAL, 32'h30, 4'b1000, 32'hA5000000, 3'd5);
    send_req(1, PUT_PARTIAL, 32'h30, 4'b1000, 32'hA5000000, 3'd5);
    drive_req(1, GET, 32'h30, 4'h0, 32'h0, 3'd6);
    get_resp(1, exp1, 2, got);
    chk("held_a_valid", 64'(a_valid[1]), 64'd1);
    exp2 = model_txn(1, GET, 32'h30, 4'h0, 32'h0, 3'd6);
    send_req(1, GET, 32'h30, 4'h0, 32'h0, 3'd6);
    get_resp(1, exp2, 0, got);
    chk("held_get_data", 64'(got[31:0]), 64'hA5ADF00D);

    // Reset during WAIT aborts the put
    send_req(1, PUT_FULL, 32'h20, 4'hF, 32'hCAFEF00D, 3'd2);
    @(negedge clk) reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_d_valid", 64'(d_valid[1]), 64'd0);
    end
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check_idle_after_reset();
    txn(1, GET, 32'h20, 4'h0, 32'h0, 3'd3, 0, got);
    chk("abort_get_data", 64'(got[31:0]), 64'd0);

    // Randomized traffic on both responders
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 40; n++) begin
        r = int'($urandom_range(0, 11));
        if (r == 0)      addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        else if (r == 1) addr = 32'h100 | ($urandom & 32'hFFFF_FFFC);
        else             addr = 32'($urandom_range(0, 15)) << 2;
        txn(i, ops[$urandom_range(0, 9)], addr, 4'($urandom), $urandom, 3'($urandom),
            int'($urandom_range(0, 3)), got);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
